// File: rtl/core_alu_seq.sv
// core_alu_seq: integer ALU with single-cycle logic/arith ops and
// iterative (one bit per cycle) multiply and divide behind a
// valid/ready request and result handshake.
module core_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [4:0]         r_op;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_opB;
  logic               r_negRes;
  logic [CW-1:0]      r_count;
  logic               r_outValid;
  logic [XLEN-1:0]    r_result;

  logic [XLEN-1:0]    w_b;
  logic [SHW-1:0]     w_shamt;
  logic               w_bZero;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_isCalc;
  logic               w_signedA;
  logic               w_signedB;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [XLEN-1:0]    w_aMag;
  logic [XLEN-1:0]    w_bMag;
  logic               w_negRes;
  logic [XLEN-1:0]    w_aluResult;

  logic [XLEN:0]      w_mulSum;
  logic [2*XLEN-1:0]  w_mulNext;
  logic [XLEN:0]      w_remShift;
  logic [XLEN:0]      w_divDiff;
  logic               w_divGe;
  logic [2*XLEN-1:0]  w_divNext;
  logic               w_calcIsMul;
  logic [2*XLEN-1:0]  w_prodAdj;
  logic [XLEN-1:0]    w_divPick;
  logic [XLEN-1:0]    w_finalResult;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_outValid;
  assign result    = r_result;

  // Decode the incoming request: operand B select, routing, and sign handling
  // so the iterative engine only ever works on unsigned magnitudes.
  always_comb begin
    w_b       = use_imm ? imm : rs2;
    w_shamt   = w_b[SHW-1:0];
    w_bZero   = (w_b == '0);
    w_isMul   = (op >= OP_MUL) && (op <= OP_MULHU);
    w_isDiv   = (op >= OP_DIV) && (op <= OP_REMU);
    w_isCalc  = w_isMul || (w_isDiv && !w_bZero);
    w_signedA = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    w_signedB = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    w_aNeg    = w_signedA & rs1[XLEN-1];
    w_bNeg    = w_signedB & w_b[XLEN-1];
    w_aMag    = w_aNeg ? ('0 - rs1) : rs1;
    w_bMag    = w_bNeg ? ('0 - w_b) : w_b;
    w_negRes  = (op == OP_REM) ? w_aNeg : (w_aNeg ^ w_bNeg);
  end

  // Single-cycle results, including the divide-by-zero shortcut and illegal codes.
  always_comb begin
    w_aluResult = '0;
    case (op)
      OP_ADD:  w_aluResult = rs1 + w_b;
      OP_SUB:  w_aluResult = rs1 - w_b;
      OP_SLL:  w_aluResult = rs1 << w_shamt;
      OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(w_b))};
      OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, (rs1 < w_b)};
      OP_XOR:  w_aluResult = rs1 ^ w_b;
      OP_SRL:  w_aluResult = rs1 >> w_shamt;
      OP_SRA:  w_aluResult = $signed(rs1) >>> w_shamt;
      OP_OR:   w_aluResult = rs1 | w_b;
      OP_AND:  w_aluResult = rs1 & w_b;
      OP_DIV,
      OP_DIVU: w_aluResult = '1;
      OP_REM,
      OP_REMU: w_aluResult = rs1;
      default: w_aluResult = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide on the shared
  // accumulator: {hi, lo} holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    w_mulSum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opB} : '0);
    w_mulNext   = {w_mulSum, r_acc[XLEN-1:1]};
    w_remShift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_divDiff   = w_remShift - {1'b0, r_opB};
    w_divGe     = ~w_divDiff[XLEN];
    w_divNext   = {(w_divGe ? w_divDiff[XLEN-1:0] : w_remShift[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_divGe};
    w_calcIsMul = (r_op >= OP_MUL) && (r_op <= OP_MULHU);
  end

  // Apply the saved sign correction to the last iteration's output and pick the
  // half (low/high product, quotient/remainder) that the operation returns.
  always_comb begin
    w_prodAdj     = r_negRes ? ('0 - w_mulNext) : w_mulNext;
    w_divPick     = ((r_op == OP_REM) || (r_op == OP_REMU)) ?
                    w_divNext[2*XLEN-1:XLEN] : w_divNext[XLEN-1:0];
    w_finalResult = '0;
    if (r_op == OP_MUL) begin
      w_finalResult = w_prodAdj[XLEN-1:0];
    end else if (w_calcIsMul) begin
      w_finalResult = w_prodAdj[2*XLEN-1:XLEN];
    end else begin
      w_finalResult = r_negRes ? ('0 - w_divPick) : w_divPick;
    end
  end

  // Control FSM with registered outputs; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_acc      <= '0;
      r_opB      <= '0;
      r_negRes   <= 1'b0;
      r_count    <= '0;
      r_outValid <= 1'b0;
      r_result   <= '0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_outValid <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_isCalc) begin
              r_state  <= S_CALC;
              r_op     <= op;
              r_acc    <= {{XLEN{1'b0}}, w_aMag};
              r_opB    <= w_bMag;
              r_negRes <= w_negRes;
              r_count  <= '0;
            end else begin
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
              r_result   <= w_aluResult;
            end
          end
        end
        S_CALC: begin
          r_acc   <= w_calcIsMul ? w_mulNext : w_divNext;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_STEP) begin
            r_state    <= S_DONE;
            r_count    <= '0;
            r_outValid <= 1'b1;
            r_result   <= w_finalResult;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
            r_result   <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_outValid <= 1'b0;
          r_result   <= '0;
        end
      endcase
    end
  end

endmodule
